// File: rtl/melody_pkg.sv
// Shared types and constants for the melody sequencer: FSM states and the
// reserved divider codes that mark a rest and the end of a melody.
package melody_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_e;

    localparam int unsigned REST_CODE = 0;

    // All-ones divider of the given width terminates a melody table.
    function automatic logic [63:0] END_CODE(input int unsigned bw);
        return (64'd1 << bw) - 64'd1;
    endfunction

endpackage

// File: rtl/melody_player_tone_gen.sv
// Square-wave generator: toggles its output every div_i enabled cycles,
// held silent when div_i is the rest code or when cleared.
module tone_gen
    import melody_pkg::*;
#(
    parameter int BW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          enable_i,
    input  logic [BW-1:0] div_i,
    output logic          square_o
);

    logic [BW-1:0] toneCnt_q, toneCnt_d;
    logic          square_q, square_d;

    // A rest keeps the counter parked so the next note starts from a clean phase.
    always_comb begin
        toneCnt_d = toneCnt_q;
        square_d  = square_q;
        if (clear_i || div_i == BW'(REST_CODE)) begin
            toneCnt_d = '0;
            square_d  = 1'b0;
        end else if (enable_i) begin
            if (toneCnt_q == div_i - BW'(1)) begin
                toneCnt_d = '0;
                square_d  = ~square_q;
            end else begin
                toneCnt_d = toneCnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            toneCnt_q <= '0;
            square_q  <= 1'b0;
        end else begin
            toneCnt_q <= toneCnt_d;
            square_q  <= square_d;
        end
    end

    assign square_o = square_q;

endmodule

// File: rtl/melody_player.sv
// Melody sequencer: walks an external divider ROM slot by slot, drives a
// tone generator and mutes the tail of each slot for articulation.
module melody_player
    import melody_pkg::*;
#(
    parameter int          BW     = 16,
    parameter int          ADDR_W = 6,
    parameter int          STEP_W = 24,
    parameter int unsigned GAP    = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              loop_i,
    input  logic [STEP_W-1:0] step_len_i,
    output logic [ADDR_W-1:0] note_index_o,
    input  logic [BW-1:0]     divider_value_i,
    output logic              audio_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [BW-1:0]     EndCode   = BW'(END_CODE(BW));
    localparam logic [ADDR_W-1:0] LastIndex = {ADDR_W{1'b1}};
    localparam logic [STEP_W-1:0] GapLen    = STEP_W'(GAP);

    state_e            state_q;
    logic [ADDR_W-1:0] index_q;
    logic [BW-1:0]     div_q;
    logic [STEP_W-1:0] stepLen_q;
    logic [STEP_W-1:0] stepCnt_q;
    logic [STEP_W-1:0] gapStart_q;
    logic              mute_q;
    logic              done_q;
    logic              square;

    logic [STEP_W-1:0] stepLen_d;
    logic [STEP_W-1:0] gapStart_d;
    logic [STEP_W-1:0] stepCntInc_d;

    // Slot length and gap threshold as they would be latched in LOAD.
    always_comb begin
        stepLen_d    = (step_len_i == '0) ? STEP_W'(1) : step_len_i;
        gapStart_d   = (stepLen_d > GapLen) ? stepLen_d - GapLen : '0;
        stepCntInc_d = stepCnt_q + STEP_W'(1);
    end

    // mute_q tracks "not in PLAY or inside the gap" for the cycle being entered,
    // so audio_o is only an AND of two registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            index_q    <= '0;
            div_q      <= '0;
            stepLen_q  <= '0;
            stepCnt_q  <= '0;
            gapStart_q <= '0;
            mute_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            mute_q <= 1'b1;
            if (stop_i) begin
                state_q <= IDLE;
            end else if (start_i) begin
                state_q   <= LOAD;
                index_q   <= '0;
                stepCnt_q <= '0;
            end else begin
                case (state_q)
                    LOAD: begin
                        if (divider_value_i == EndCode) begin
                            if (loop_i && index_q != '0) begin
                                index_q <= '0;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end
                        end else begin
                            div_q      <= divider_value_i;
                            stepLen_q  <= stepLen_d;
                            gapStart_q <= gapStart_d;
                            stepCnt_q  <= '0;
                            mute_q     <= (gapStart_d == '0);
                            state_q    <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (stepCnt_q == stepLen_q - STEP_W'(1)) begin
                            stepCnt_q <= '0;
                            if (index_q != LastIndex) begin
                                index_q <= index_q + ADDR_W'(1);
                                state_q <= LOAD;
                            end else if (loop_i) begin
                                index_q <= '0;
                                state_q <= LOAD;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end
                        end else begin
                            stepCnt_q <= stepCntInc_d;
                            mute_q    <= (stepCntInc_d >= gapStart_q);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    tone_gen #(
        .BW(BW)
    ) u_tone_gen (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (state_q != PLAY),
        .enable_i(state_q == PLAY),
        .div_i   (div_q),
        .square_o(square)
    );

    assign note_index_o = index_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;
    assign audio_o      = square & ~mute_q;

endmodule

// File: tb/tb_melody_player.sv
// Directed bench for melody_player: three instances (GAP 0, 4, 20) share one
// ROM table and one set of controls; expected values are hand-computed.
module tb_melody_player;

    localparam int BW     = 4;
    localparam int ADDR_W = 2;
    localparam int STEP_W = 24;

    logic              clk    = 1'b0;
    logic              rst    = 1'b0;
    logic              start  = 1'b0;
    logic              stop   = 1'b0;
    logic              loopEn = 1'b0;
    logic [STEP_W-1:0] stepLen = 24'd12;
    logic [BW-1:0]     rom [4];

    logic [ADDR_W-1:0] idx0, idx4, idx20;
    logic              audio0, audio4, audio20;
    logic              busy0, busy4, busy20;
    logic              done0, done4, done20;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    melody_player #(.BW(BW), .ADDR_W(ADDR_W), .STEP_W(STEP_W), .GAP(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .loop_i(loopEn),
        .step_len_i(stepLen), .note_index_o(idx0), .divider_value_i(rom[idx0]),
        .audio_o(audio0), .busy_o(busy0), .done_o(done0)
    );

    melody_player #(.BW(BW), .ADDR_W(ADDR_W), .STEP_W(STEP_W), .GAP(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .loop_i(loopEn),
        .step_len_i(stepLen), .note_index_o(idx4), .divider_value_i(rom[idx4]),
        .audio_o(audio4), .busy_o(busy4), .done_o(done4)
    );

    melody_player #(.BW(BW), .ADDR_W(ADDR_W), .STEP_W(STEP_W), .GAP(20)) dut20 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .loop_i(loopEn),
        .step_len_i(stepLen), .note_index_o(idx20), .divider_value_i(rom[idx20]),
        .audio_o(audio20), .busy_o(busy20), .done_o(done20)
    );

    // Advance n clocks and settle just after the rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic st, input logic sp, input logic lp,
                                 input logic [STEP_W-1:0] len);
        start   = st;
        stop    = sp;
        loopEn  = lp;
        stepLen = len;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        rom = '{4'd3, 4'd0, 4'd1, 4'd15};
        #1 rst = 1'b1;
        #2;
        checkOutput("reset_audio", audio0, 0);
        checkOutput("reset_busy", busy0, 0);
        checkOutput("reset_done", done0, 0);
        checkOutput("reset_index", idx0, 0);
        tick(2);
        rst = 1'b0;

        // No start: nothing may move for 100 cycles.
        for (int i = 0; i < 100; i++) begin
            tick(1);
            checkOutput($sformatf("idle_c%0d", i), {busy0, done0, audio0, idx0}, 0);
        end

        // Basic tone with ROM {3, 0, 1, END}, 12-cycle slots.
        applyStimulus(1, 0, 0, 12);
        tick(1);
        applyStimulus(0, 0, 0, 12);
        checkOutput("basic_load_busy", busy0, 1);
        checkOutput("basic_load_idx0", idx0, 0);
        tick(1);
        for (int k = 0; k < 12; k++) begin
            checkOutput($sformatf("basic_n0_k%0d", k), audio0, ((k >= 3 && k < 6) || k >= 9));
            tick(1);
        end
        checkOutput("basic_idx1", idx0, 1);
        checkOutput("basic_load1_audio", audio0, 0);
        tick(1);
        for (int k = 0; k < 12; k++) begin
            checkOutput($sformatf("basic_rest_k%0d", k), audio0, 0);
            tick(1);
        end
        checkOutput("basic_idx2", idx0, 2);
        tick(1);
        for (int k = 0; k < 12; k++) begin
            checkOutput($sformatf("basic_n2_k%0d", k), audio0, k % 2);
            tick(1);
        end
        checkOutput("basic_idx3", idx0, 3);
        checkOutput("basic_end_load_busy", busy0, 1);
        checkOutput("basic_end_load_done", done0, 0);
        tick(1);
        checkOutput("basic_done_pulse", done0, 1);
        checkOutput("basic_done_busy", busy0, 0);
        tick(1);
        checkOutput("basic_done_clear", done0, 0);

        // Looping over a table with no END marker, 2-cycle slots.
        rom = '{4'd1, 4'd2, 4'd3, 4'd1};
        applyStimulus(1, 0, 1, 2);
        tick(1);
        applyStimulus(0, 0, 1, 2);
        for (int s = 0; s < 6; s++) begin
            checkOutput($sformatf("loop_s%0d_idx", s), idx0, s % 4);
            checkOutput($sformatf("loop_s%0d_busy", s), busy0, 1);
            checkOutput($sformatf("loop_s%0d_done", s), done0, 0);
            tick(3);
        end
        checkOutput("loop_drop_idx2", idx0, 2);
        tick(1);
        applyStimulus(0, 0, 0, 2);
        tick(2);
        checkOutput("loop_drop_idx3", idx0, 3);
        checkOutput("loop_drop_busy", busy0, 1);
        tick(3);
        checkOutput("loop_drop_done", done0, 1);
        checkOutput("loop_drop_idle", busy0, 0);
        checkOutput("loop_drop_audio", audio0, 0);

        // Gap articulation: divider 2 everywhere, 12-cycle slots.
        rom = '{4'd2, 4'd2, 4'd2, 4'd2};
        applyStimulus(1, 0, 0, 12);
        tick(1);
        applyStimulus(0, 0, 0, 12);
        tick(1);
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 12; k++) begin
                checkOutput($sformatf("gap0_s%0d_k%0d", s, k), audio0, (k / 2) % 2);
                checkOutput($sformatf("gap4_s%0d_k%0d", s, k), audio4, ((k / 2) % 2 == 1) && k < 8);
                checkOutput($sformatf("gap20_s%0d_k%0d", s, k), audio20, 0);
                tick(1);
            end
            checkOutput($sformatf("gap4_s%0d_load", s), audio4, 0);
            tick(1);
        end
        tick(6);
        checkOutput("midrst_pre_audio", audio0, 1);
        rst = 1'b1;
        tick(1);
        checkOutput("midrst_audio", audio0, 0);
        checkOutput("midrst_busy", busy0, 0);
        checkOutput("midrst_done", done0, 0);
        checkOutput("midrst_idx", idx0, 0);
        checkOutput("midrst_audio4", audio4, 0);
        rst = 1'b0;
        tick(1);

        // Control races with ROM {3, 0, 1, END}, 4-cycle slots.
        rom = '{4'd3, 4'd0, 4'd1, 4'd15};
        applyStimulus(1, 1, 0, 4);
        tick(1);
        applyStimulus(0, 0, 0, 4);
        checkOutput("race_startstop_busy", busy0, 0);
        tick(1);
        checkOutput("race_startstop_busy2", busy0, 0);

        applyStimulus(1, 0, 0, 4);
        tick(1);
        applyStimulus(0, 0, 0, 4);
        tick(12);
        checkOutput("race_mid2_idx", idx0, 2);
        checkOutput("race_mid2_busy", busy0, 1);
        applyStimulus(1, 0, 0, 4);
        tick(1);
        applyStimulus(0, 0, 0, 4);
        checkOutput("race_restart_idx", idx0, 0);
        checkOutput("race_restart_busy", busy0, 1);
        checkOutput("race_restart_audio", audio0, 0);

        tick(5);
        checkOutput("race_load1_idx", idx0, 1);
        applyStimulus(0, 1, 0, 4);
        tick(1);
        applyStimulus(0, 0, 0, 4);
        checkOutput("race_stop_busy", busy0, 0);
        checkOutput("race_stop_done", done0, 0);
        checkOutput("race_stop_idx_held", idx0, 1);
        tick(1);
        checkOutput("race_stop_done2", done0, 0);

        applyStimulus(1, 0, 0, 0);
        tick(1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("step0_idx0", idx0, 0);
        tick(2);
        checkOutput("step0_idx1", idx0, 1);
        checkOutput("step0_busy", busy0, 1);
        tick(4);
        checkOutput("step0_idx3", idx0, 3);
        tick(1);
        checkOutput("step0_done", done0, 1);
        checkOutput("step0_idle", busy0, 0);

        // END at index 0 with looping enabled must terminate.
        rom = '{4'd15, 4'd0, 4'd1, 4'd15};
        tick(1);
        applyStimulus(1, 0, 1, 4);
        tick(1);
        applyStimulus(0, 0, 1, 4);
        checkOutput("end0_load_busy", busy0, 1);
        tick(1);
        checkOutput("end0_done", done0, 1);
        checkOutput("end0_busy", busy0, 0);
        tick(1);
        checkOutput("end0_done_clear", done0, 0);
        tick(5);
        checkOutput("end0_stays_idle", {busy0, done0}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/melody_player.md
# melody_player

Parametrised melody sequencer with a built-in square-wave tone generator. It walks a note table held in an external combinational divider ROM, one slot at a time, and produces a single-bit audio output. It supports start/stop, looping, programmable slot length, an articulation gap and an end-of-melody marker. It sits between the note ROM and the audio output pin, replacing free-running index counters in the top level.

## Interface

**Parameters**
- `BW`, 16: divider width; ROM word width.
- `ADDR_W`, 6: note-index width; table depth is 2^ADDR_W.
- `STEP_W`, 24: slot-length width.
- `GAP`, 0: number of muted cycles at the end of each slot. Must be less than 2^STEP_W.

**Ports** (name, direction, width, meaning)
- `clk_i`, in, 1: clock. One clock domain only.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `start_i`, in, 1: start, or restart, from index 0.
- `stop_i`, in, 1: abort playback; go idle.
- `loop_i`, in, 1: on melody end, wrap to index 0 instead of stopping.
- `step_len_i`, in, STEP_W: PLAY cycles per slot. A value of 0 is treated as 1.
- `note_index_o`, out, ADDR_W: registered address to the note ROM.
- `divider_value_i`, in, BW: ROM data, combinational from `note_index_o`.
- `audio_o`, out, 1: square-wave output.
- `busy_o`, out, 1: high whenever the block is not in IDLE.
- `done_o`, out, 1: one-cycle pulse when the melody ends without looping.

## Operation

**ROM encoding**
- Divider 0 = rest.
- Divider all-ones (`END_CODE`) = end of melody.
- Any other value D = half-period of D cycles.

**States**
- IDLE:
  - `start_i` && !`stop_i`: index ← 0, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (exactly 1 cycle): `note_index_o` is stable; evaluate `divider_value_i`.
  - Value is END_CODE:
    - If `loop_i` and index ≠ 0: index ← 0, stay in LOAD.
    - Else: `done_o` pulse, go to IDLE. END_CODE at index 0 never spins, even with `loop_i` set.
  - Otherwise: div_q ← `divider_value_i`; step_q ← max(`step_len_i`, 1); step_cnt ← 0; tone_cnt ← 0; audio ← 0; go to PLAY.
- PLAY:
  - step_cnt increments each cycle.
  - When step_cnt == step_q−1, the slot ends:
    - Index < 2^ADDR_W−1: index+1, go to LOAD.
    - Last index with `loop_i`: index wraps to 0, go to LOAD.
    - Last index without `loop_i`: `done_o` pulse, go to IDLE.

**Tone generator (PLAY only)**
- div_q == 0: audio held at 0; tone_cnt held at 0.
- Otherwise tone_cnt counts 0..div_q−1. On tone_cnt == div_q−1, tone_cnt ← 0 and audio toggles.
- div_q == 1 toggles audio every cycle.

**Gap**
- `audio_o` = audio && !(step_cnt ≥ step_q−GAP), evaluated with unsigned compare and saturated at 0.
- The tone counter keeps running during the gap.
- If GAP ≥ step_q, the whole slot is silent.

**Priority and control**
- `stop_i` beats `start_i` and beats every state transition. `stop_i` → IDLE next cycle with `audio_o` at 0, `note_index_o` held, and no `done_o`.
- `start_i` in LOAD or PLAY restarts: index ← 0, go to LOAD. A slot in progress is discarded.
- `loop_i` and `step_len_i` are sampled only at slot ends and in LOAD respectively. Mid-slot changes have no effect on the current slot.
- `rst_i` mid-playback behaves the same as reset from power-up.

## Timing

- Reset values:
  - `audio_o` = 0
  - `busy_o` = 0
  - `done_o` = 0
  - `note_index_o` = 0
  - state = IDLE
  - all counters = 0
- `start_i` asserted in cycle N: LOAD in N+1 (`busy_o` = 1), first PLAY cycle in N+2.
- Slot period = 1 LOAD + step_q PLAY cycles.
- First audio toggle occurs D PLAY cycles after entering PLAY.
- `done_o` goes high in the first IDLE cycle, coincident with `busy_o` falling.
- All outputs are registered except the `audio_o` gap gating, which is a single AND of registered terms.

## Structure

- Package `melody_pkg`: state enum {IDLE, LOAD, PLAY}, an `END_CODE(BW)` constant function, and the rest code 0.
- Sub-module `tone_gen` (BW): inputs clk/rst, clear, enable, div; output square. It holds tone_cnt and the toggle register.
- Top level: FSM, index counter, step counter and gap gating.
- The ROM stays external, so existing note ROMs plug in unchanged. Tables that fit in fewer slots terminate with END_CODE.

## Test plan

- **Reset and idle:** assert `rst_i` mid-PLAY → all outputs 0 next cycle. `start_i` is held low for 100 cycles after reset → no activity.
- **Basic tone:** BW=4, ADDR_W=2, ROM = {3, 0, 1, 15}, `step_len_i`=12, GAP=0, one `start_i` pulse.
  - Index 0: audio toggles at PLAY cycles 3, 6, 9 and 12 of the slot, relative to entry.
  - Index 1: silent.
  - Index 2: toggles every cycle.
  - Index 3: END → `done_o` pulse at the cycle count predicted by the spec.
- **Loop and wrap:** ROM with no END and `loop_i`=1 → the index sequence 0,1,2,3,0 repeats and `done_o` is never asserted. Drop `loop_i` during index 2 → the block stops after index 3 and pulses `done_o`.
- **Gap articulation:** GAP=4, `step_len_i`=12, ROM {2, 2, …} → audio is 0 in PLAY cycles 8–11 of each slot; repeated notes are audibly separated. GAP=20 → every slot is silent.
- **Control races:**
  - `start_i` and `stop_i` in the same cycle → IDLE.
  - `start_i` mid-slot 2 → LOAD at index 0.
  - `stop_i` in LOAD → IDLE with no `done_o`.
  - `step_len_i`=0 → one PLAY cycle per slot.
- **END at index 0 with `loop_i`=1** → `done_o` pulses once and `busy_o` drops; the block does not livelock.
